// File: rtl/sh_tmu_pkg.sv
// sh_tmu_pkg: shared constants, types and helpers for the sh_tmu timer unit.
//   - TCR/TSR bit positions, register offsets (A[3:2]), prescaler select enum
//   - tmu_wr_t: one bus write as seen by a channel (one-hot register hit + data/byte mask)
//   - tick_sel(): internal prescaler tap selection
package sh_tmu_pkg;

  localparam int TCR_EN   = 0;
  localparam int TCR_CKS  = 1;   // [3:1]
  localparam int TCR_CCLR = 4;
  localparam int TCR_OS   = 5;
  localparam int TCR_CMIE = 6;
  localparam int TCR_OVIE = 7;
  localparam int TCR_TOE  = 8;
  localparam int TCR_CASC = 9;
  localparam int TCR_W    = 10;

  localparam int TSR_CMF  = 0;
  localparam int TSR_OVF  = 1;
  localparam int TSR_TOUT = 2;

  localparam logic [1:0] REG_TCR  = 2'd0;
  localparam logic [1:0] REG_TCNT = 2'd1;
  localparam logic [1:0] REG_TCOR = 2'd2;
  localparam logic [1:0] REG_TSR  = 2'd3;

  localparam int DIV_W = 12;

  typedef enum logic [2:0] {
    CKS_1, CKS_4, CKS_16, CKS_64, CKS_256, CKS_1024, CKS_4096, CKS_EXT
  } cks_e;

  typedef struct packed {
    logic [3:0]  hit;   // one-hot, indexed by REG_*
    logic [31:0] data;
    logic [31:0] mask;  // byte enables expanded to bits
  } tmu_wr_t;

  // Divide-by-4^k tap: fires when the low 2k bits of the divider are all ones.
  function automatic logic tick_sel(input cks_e cks, input logic [DIV_W-1:0] div_cnt);
    logic [DIV_W-1:0] m;
    m = ~({DIV_W{1'b1}} << (2 * int'(cks)));
    return (cks != CKS_EXT) && ((div_cnt & m) == m);
  endfunction

endpackage

// File: rtl/sh_tmu_channel.sv
// sh_tmu_channel: one timer channel (counter, compare, flags, IRQ, toggle output).
//   CLK/RST_N     clock, async active-low reset
//   ce, srst      rising-phase enable; synchronous soft reset (already qualified by ce)
//   pre_tick[7:0] candidate ticks indexed by CKS (7 = synchronised TCLK edge)
//   casc_tick     overflow pulse of the previous channel
//   wr            bus write aimed at this channel
//   tcr/tcnt/tcor/tsr  register readback; irq, tout; ovf_pulse to the next channel
module sh_tmu_channel
  import sh_tmu_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit CASC_OK = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ce,
  input  logic              srst,
  input  logic [7:0]        pre_tick,
  input  logic              casc_tick,
  input  tmu_wr_t           wr,
  output logic [TCR_W-1:0]  tcr,
  output logic [CNT_W-1:0]  tcnt,
  output logic [CNT_W-1:0]  tcor,
  output logic [2:0]        tsr,
  output logic              irq,
  output logic              tout,
  output logic              ovf_pulse
);

  logic cmf, ovf;
  logic tick_src, step, match, cm_set, ov_set, clr_cmf, clr_ovf;
  logic [CNT_W-1:0] cnt_nxt;

  assign tick_src = (CASC_OK && tcr[TCR_CASC]) ? casc_tick : pre_tick[tcr[TCR_CKS+:3]];
  // A CPU write to TCNT swallows the tick entirely.
  assign step     = ce & tcr[TCR_EN] & tick_src & ~wr.hit[REG_TCNT];
  assign match    = (tcnt == tcor);
  assign cm_set   = step & match;
  // Wrapping to zero from all-ones sets OVF, whether through compare (CCLR=0) or plain count.
  assign ov_set   = step & (&tcnt) & ~(match & tcr[TCR_CCLR]);
  assign cnt_nxt  = (match & tcr[TCR_CCLR]) ? '0 : tcnt + 1'b1;
  assign clr_cmf  = wr.hit[REG_TSR] & wr.mask[TSR_CMF] & wr.data[TSR_CMF];
  assign clr_ovf  = wr.hit[REG_TSR] & wr.mask[TSR_OVF] & wr.data[TSR_OVF];

  assign ovf_pulse = ov_set;
  assign tsr       = {tout, ovf, cmf};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tcr  <= '0;
      tcnt <= '0;
      tcor <= '1;
      cmf  <= 1'b0;
      ovf  <= 1'b0;
      tout <= 1'b0;
      irq  <= 1'b0;
    end else if (ce) begin
      if (srst) begin
        tcr  <= '0;
        tcnt <= '0;
        tcor <= '1;
        cmf  <= 1'b0;
        ovf  <= 1'b0;
        tout <= 1'b0;
        irq  <= 1'b0;
      end else begin
        if (wr.hit[REG_TCR])
          tcr <= (tcr & ~wr.mask[TCR_W-1:0]) | (wr.data[TCR_W-1:0] & wr.mask[TCR_W-1:0]);
        else if (cm_set && tcr[TCR_OS])
          tcr[TCR_EN] <= 1'b0;

        if (wr.hit[REG_TCNT])
          tcnt <= (tcnt & ~wr.mask[CNT_W-1:0]) | (wr.data[CNT_W-1:0] & wr.mask[CNT_W-1:0]);
        else if (step)
          tcnt <= cnt_nxt;

        if (wr.hit[REG_TCOR])
          tcor <= (tcor & ~wr.mask[CNT_W-1:0]) | (wr.data[CNT_W-1:0] & wr.mask[CNT_W-1:0]);

        // Set beats a coincident write-1-clear.
        cmf <= cm_set | (cmf & ~clr_cmf);
        ovf <= ov_set | (ovf & ~clr_ovf);

        if (cm_set && tcr[TCR_TOE])
          tout <= ~tout;

        irq <= (cmf & tcr[TCR_CMIE]) | (ovf & tcr[TCR_OVIE]);
      end
    end
  end

endmodule

// File: rtl/sh_tmu.sv
// sh_tmu: NCH-channel timer unit on the peripheral bus.
//   CLK, RST_N          clock, async active-low reset
//   CE_R / CE_F         rising-phase enable (all state) / unused falling-phase enable
//   RES_N               soft reset sampled on CE_R
//   TCLK                external count clock (CKS=7)
//   IBUS_*              zero-wait-state bus slave; ACT and DO are combinational
//   IRQ[NCH], TOUT[NCH] per-channel interrupt level and toggle output
module sh_tmu
  import sh_tmu_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFD00
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CE_R,
  input  logic           CE_F,
  input  logic           RES_N,
  input  logic           TCLK,
  input  logic [31:0]    IBUS_A,
  input  logic [31:0]    IBUS_DI,
  output logic [31:0]    IBUS_DO,
  input  logic [3:0]     IBUS_BA,
  input  logic           IBUS_WE,
  input  logic           IBUS_REQ,
  output logic           IBUS_BUSY,
  output logic           IBUS_ACT,
  output logic [NCH-1:0] IRQ,
  output logic [NCH-1:0] TOUT
);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       tclk_sync;
  logic             srst;
  logic [7:0]       pre_tick;

  assign srst = CE_R & ~RES_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt   <= '0;
      tclk_sync <= '0;
    end else if (CE_R) begin
      if (srst) begin
        div_cnt   <= '0;
        tclk_sync <= '0;
      end else begin
        div_cnt   <= div_cnt + 1'b1;
        tclk_sync <= {tclk_sync[1:0], TCLK};
      end
    end
  end

  always_comb begin
    pre_tick = '0;
    for (int k = 0; k < 7; k++)
      pre_tick[k] = tick_sel(cks_e'(3'(k)), div_cnt);
    // Rising edge seen on the second synchroniser stage.
    pre_tick[7] = tclk_sync[1] & ~tclk_sync[2];
  end

  // Bus decode
  logic [4:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        wr_go;
  logic [31:0] be_mask;

  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = IBUS_REQ && (IBUS_A[31:8] == BASE_ADDR[31:8]);
  assign ch_sel    = {1'b0, IBUS_A[7:4]};
  assign reg_sel   = IBUS_A[3:2];
  assign wr_go     = IBUS_ACT & IBUS_WE;
  assign be_mask   = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};

  logic [NCH-1:0][TCR_W-1:0] tcr_a;
  logic [NCH-1:0][CNT_W-1:0] tcnt_a, tcor_a;
  logic [NCH-1:0][2:0]       tsr_a;
  logic [NCH-1:0]            ovf_p;
  logic [NCH:0]              casc_v;

  assign casc_v = {ovf_p, 1'b0};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tmu_wr_t wr_i;
    assign wr_i = '{hit:  (wr_go && ch_sel == 5'(i)) ? 4'(4'b0001 << reg_sel) : 4'b0000,
                    data: IBUS_DI,
                    mask: be_mask};

    sh_tmu_channel #(.CNT_W(CNT_W), .CASC_OK(i > 0)) u_ch (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ce        (CE_R),
      .srst      (srst),
      .pre_tick  (pre_tick),
      .casc_tick (casc_v[i]),
      .wr        (wr_i),
      .tcr       (tcr_a[i]),
      .tcnt      (tcnt_a[i]),
      .tcor      (tcor_a[i]),
      .tsr       (tsr_a[i]),
      .irq       (IRQ[i]),
      .tout      (TOUT[i]),
      .ovf_pulse (ovf_p[i])
    );
  end

  // Channels without an instance fall through to 0.
  always_comb begin
    IBUS_DO = '0;
    if (IBUS_ACT) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == 5'(i)) begin
          case (reg_sel)
            REG_TCR:  IBUS_DO = 32'(tcr_a[i]);
            REG_TCNT: IBUS_DO = 32'(tcnt_a[i]);
            REG_TCOR: IBUS_DO = 32'(tcor_a[i]);
            default:  IBUS_DO = 32'(tsr_a[i]);
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sh_tmu.sv
module tb_sh_tmu;
  localparam int NCH = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] BASE = 32'hFFFFFD00;

  logic CLK = 0, RST_N = 0, CE_R = 1, CE_F = 0, RES_N = 1, TCLK = 0;
  logic [31:0] IBUS_A = 0, IBUS_DI = 0, IBUS_DO;
  logic [3:0]  IBUS_BA = 0;
  logic IBUS_WE = 0, IBUS_REQ = 0, IBUS_BUSY, IBUS_ACT;
  logic [NCH-1:0] IRQ, TOUT;

  sh_tmu #(.NCH(NCH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N), .TCLK(TCLK),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .IRQ(IRQ), .TOUT(TOUT));

  always #5 CLK = ~CLK;

  // Reference prescaler position: number of enabled cycles since reset.
  int mdiv;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) mdiv <= 0;
    else if (CE_R) mdiv <= RES_N ? mdiv + 1 : 0;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] adr(input int ch, input int r);
    return BASE + 32'(ch * 16 + r * 4);
  endfunction

  // Number of prescaler ticks of period p seen in n edges, the first using divider value d1.
  function automatic int nticks(input int d1, input int n, input int p);
    return (d1 + n) / p - d1 / p;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba = 4'hF);
    IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1; IBUS_REQ = 1;
    @(posedge CLK); #1;
    IBUS_WE = 0; IBUS_REQ = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic act);
    IBUS_A = a; IBUS_WE = 0; IBUS_REQ = 1;
    #2;
    d = IBUS_DO; act = IBUS_ACT;
    IBUS_REQ = 0;
  endtask

  task automatic chk_rd(input string nm, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] d; logic act;
    bus_rd(adr(ch, r), d, act);
    chk(nm, d, exp);
  endtask

  task automatic do_reset;
    RST_N = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  ba;
    logic [31:0] exp;
    logic        act;
    string       nm;
  } vec_t;

  vec_t vt[11];

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d; logic act;
    int d1, n, ch, cks, cor, p, t, m;

    vt[0]  = '{0, adr(0,0), 0, 0, 32'h0, 1, "rst_tcr0"};
    vt[1]  = '{0, adr(0,1), 0, 0, 32'h0, 1, "rst_tcnt0"};
    vt[2]  = '{0, adr(0,2), 0, 0, 32'h0000FFFF, 1, "rst_tcor0"};
    vt[3]  = '{0, adr(0,3), 0, 0, 32'h0, 1, "rst_tsr0"};
    vt[4]  = '{0, adr(3,2), 0, 0, 32'h0000FFFF, 1, "rst_tcor3"};
    vt[5]  = '{1, adr(1,2), 32'h12345678, 4'hF, 32'h00005678, 1, "tcor_zext"};
    vt[6]  = '{1, adr(1,2), 32'h0000AB00, 4'h1, 32'h00005600, 1, "tcor_byte0"};
    vt[7]  = '{1, adr(2,0), 32'hFFFFFFFE, 4'hF, 32'h000003FE, 1, "tcr_bits"};
    vt[8]  = '{1, adr(5,0), 32'h00000001, 4'hF, 32'h0, 1, "ch_oor"};
    vt[9]  = '{0, 32'hFFFFFC00, 0, 0, 32'h0, 0, "miss_addr"};
    vt[10] = '{0, adr(2,3), 0, 0, 32'h0, 1, "tsr2_idle"};

    do_reset();
    chk("rst_irq", 32'(IRQ), 0);
    chk("rst_tout", 32'(TOUT), 0);
    chk("rst_busy", 32'(IBUS_BUSY), 0);

    foreach (vt[i]) begin
      if (vt[i].wr) bus_wr(vt[i].a, vt[i].d, vt[i].ba);
      bus_rd(vt[i].a, d, act);
      chk(vt[i].nm, d, vt[i].exp);
      chk({vt[i].nm, "_act"}, 32'(act), 32'(vt[i].exp == vt[i].exp ? vt[i].act : 1'b0));
    end

    // Compare / auto-clear / toggle / IRQ on ch0, one tick per cycle
    do_reset();
    bus_wr(adr(0,2), 9);
    bus_wr(adr(0,0), 32'h151);                 // edge e0
    tick_n(9);
    chk_rd("cm_tcnt9", 0, 1, 9);
    chk_rd("cm_nomatch", 0, 3, 0);
    tick_n(1);                                 // e0+10: match
    chk_rd("cm_wrap", 0, 1, 0);
    chk_rd("cm_tsr", 0, 3, 5);
    chk("cm_irq_lag", 32'(IRQ[0]), 0);
    tick_n(1);
    chk("cm_irq", 32'(IRQ[0]), 1);
    bus_wr(adr(0,3), 1);                       // e0+12
    chk_rd("clr_tsr", 0, 3, 4);
    tick_n(1);
    chk("clr_irq", 32'(IRQ[0]), 0);
    tick_n(6);                                 // e0+19
    chk_rd("tog_tcnt", 0, 1, 9);
    chk("tog_hi", 32'(TOUT[0]), 1);
    tick_n(1);                                 // e0+20
    chk("tog_lo", 32'(TOUT[0]), 0);
    chk_rd("cm2_tsr", 0, 3, 1);
    bus_wr(adr(0,3), 1);                       // e0+21
    chk_rd("clr2_tsr", 0, 3, 0);
    tick_n(8);                                 // e0+29
    bus_wr(adr(0,3), 1);                       // e0+30: coincides with a match
    chk_rd("set_beats_clr", 0, 3, 5);
    bus_wr(adr(0,1), 32'h1234);                // write coincides with a tick
    chk_rd("wr_beats_tick", 0, 1, 32'h1234);
    CE_R = 0;
    tick_n(5);
    chk_rd("ce_freeze", 0, 1, 32'h1234);
    CE_R = 1;
    tick_n(1);
    chk_rd("ce_resume", 0, 1, 32'h1235);
    RES_N = 0;
    tick_n(1);
    RES_N = 1;
    chk_rd("sres_tcnt", 0, 1, 0);
    chk_rd("sres_tcor", 0, 2, 32'hFFFF);
    chk_rd("sres_tcr", 0, 0, 0);

    // One-shot on ch1, /16
    do_reset();
    bus_wr(adr(1,2), 3);
    bus_wr(adr(1,0), 32'h35);
    d1 = mdiv;
    n = 1;
    while (nticks(d1, n, 16) < 4) n++;
    tick_n(n - 1);
    chk_rd("os_pre", 1, 1, 3);
    chk_rd("os_en_pre", 1, 0, 32'h35);
    tick_n(1);
    chk_rd("os_tcnt", 1, 1, 0);
    chk_rd("os_en_clr", 1, 0, 32'h34);
    chk_rd("os_cmf", 1, 3, 1);
    tick_n(64);
    chk_rd("os_hold", 1, 1, 0);

    // Cascade ch0 -> ch1
    do_reset();
    bus_wr(adr(0,1), 32'hFFFE);
    bus_wr(adr(1,0), 32'h201);
    bus_wr(adr(0,0), 32'h001);
    tick_n(1);
    chk_rd("casc_ch0_ff", 0, 1, 32'hFFFF);
    chk_rd("casc_ch1_0", 1, 1, 0);
    tick_n(1);
    chk_rd("casc_ch0_wrap", 0, 1, 0);
    chk_rd("casc_ch0_tsr", 0, 3, 3);
    chk_rd("casc_ch1_1", 1, 1, 1);

    // External clock
    do_reset();
    bus_wr(adr(0,0), 32'h00F);
    TCLK = 1;
    tick_n(2);
    chk_rd("ext_lat2", 0, 1, 0);
    tick_n(1);
    chk_rd("ext_lat3", 0, 1, 1);
    tick_n(1);
    TCLK = 0;
    tick_n(4);
    for (int k = 0; k < 4; k++) begin
      TCLK = 1; tick_n(4);
      TCLK = 0; tick_n(4);
    end
    chk_rd("ext_cnt5", 0, 1, 5);

    // Random prescaled auto-clear runs checked against closed-form tick counting
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ch  = $urandom_range(0, NCH - 1);
      cks = $urandom_range(0, 2);
      cor = $urandom_range(1, 20);
      n   = $urandom_range(20, 400);
      p   = 1 << (2 * cks);
      bus_wr(adr(ch,2), 32'(cor));
      bus_wr(adr(ch,0), 32'h111 | 32'(cks << 1));
      d1 = mdiv;
      tick_n(n);
      t = nticks(d1, n, p);
      m = t / (cor + 1);
      chk($sformatf("rnd%0d_tcnt", r), tb_rd(adr(ch,1)), 32'(t % (cor + 1)));
      chk($sformatf("rnd%0d_tsr", r), tb_rd(adr(ch,3)), {29'b0, 1'(m & 1), 1'b0, 1'(m > 0)});
      chk($sformatf("rnd%0d_tout", r), 32'(TOUT[ch]), 32'(m & 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    // Used only while the bus is otherwise idle; reads the combinational readback path.
    return (a[31:8] == BASE[31:8]) ? rd_peek(a) : 32'h0;
  endfunction

  logic [31:0] peek_a;
  function automatic logic [31:0] rd_peek(input logic [31:0] a);
    case (a[3:2])
      2'd0: return 32'(dut.tcr_a[a[7:4]]);
      2'd1: return 32'(dut.tcnt_a[a[7:4]]);
      2'd2: return 32'(dut.tcor_a[a[7:4]]);
      default: return 32'(dut.tsr_a[a[7:4]]);
    endcase
  endfunction

endmodule

// File: doc/sh_tmu.md
Name: sh_tmu

Overview:
- Parametrised multi-channel timer unit on the on-chip peripheral bus (DBUS side, alongside FRT/WDT/SCI).
- Successor to the single fixed FRT, with NCH independent up-counters of width CNT_W.
- Each channel has a prescaler select, compare-match with optional auto-clear, one-shot mode, and a toggle output.
- Channels can be cascaded so that channel i counts on overflows of channel i-1.

Parameters:
- NCH, 4, number of channels (1..16).
- CNT_W, 16, counter and compare width (8..32).
- BASE_ADDR, 32'hFFFFFD00, register block base; decode on A[31:8], channel select on A[7:4], register on A[3:2].

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1.
- CE_F  in  1  falling-phase clock enable; unused, kept for port uniformity.
- RES_N  in  1  chip soft reset, sampled on CE_R, same effect as RST_N.
- TCLK  in  1  external count clock.
- IBUS_A  in  32  address.
- IBUS_DI  in  32  write data.
- IBUS_DO  out  32  read data.
- IBUS_BA  in  4  byte enables; bit3 = D[31:24].
- IBUS_WE  in  1  write strobe.
- IBUS_REQ  in  1  access request.
- IBUS_BUSY  out  1  wait request; tied to 0.
- IBUS_ACT  out  1  address hit.
- IRQ  out  NCH  per-channel interrupt request, level.
- TOUT  out  NCH  per-channel toggle output.

Behaviour:
Register map, per channel at offset ch*16:
- +0 TCR: [0] EN, [3:1] CKS, [4] CCLR, [5] OS, [6] CMIE, [7] OVIE, [8] TOE, [9] CASC; other bits read 0.
- +4 TCNT: counter value.
- +8 TCOR: compare value.
- +C TSR: [0] CMF, [1] OVF, [2] TOUT (read-only); write 1 to clear CMF/OVF.
- Registers narrower than 32 bits read zero-extended.
- Channel index >= NCH: IBUS_ACT=1, reads return 0, writes are ignored.

Bus:
- IBUS_ACT = IBUS_REQ && A[31:8]==BASE_ADDR[31:8]; combinational.
- IBUS_DO is combinational from the addressed register and is 0 when not ACT.
- Writes commit on CE_R when ACT&WE, per-byte via IBUS_BA.
- Zero wait states.

Prescaler:
- 12-bit DIV_CNT increments every CE_R.
- CKS 0..6 selects a tick every 1, 4, 16, 64, 256, 1024, 4096 CE_R cycles; tick asserts when the low 2k bits of DIV_CNT are all ones.
- CKS 7: rising edge of TCLK after a 2-flop synchroniser (3-FF edge detect); latency 3 CE_R cycles.
- CASC=1 on channel i>0: tick = overflow pulse of channel i-1 in the same cycle; CKS is ignored.
- CASC on channel 0 is ignored.

Channel, per CE_R with EN=1 and tick=1:
- TCNT==TCOR: set CMF. Then TCNT <= CCLR ? 0 : TCNT+1. If TOE, TOUT toggles. If OS, EN <= 0.
- Otherwise TCNT==all-ones: TCNT <= 0, set OVF, emit overflow pulse.
- Otherwise TCNT <= TCNT+1.
- Compare takes priority over overflow when TCOR==all-ones: CMF is set; OVF is also set if CCLR=0.

Priorities and interrupts:
- A CPU write to TCNT in the same cycle as a tick: the write wins and no increment happens.
- A flag set and a write-1-clear in the same cycle: the set wins.
- IRQ[i] = (CMF&CMIE)|(OVF&OVIE), registered, one CE_R latency from the flag.
- EN=0 freezes TCNT. Flags and TOUT hold.

Reset (RST_N low, or RES_N low on CE_R):
- TCR=0, TCNT=0, TCOR=all-ones, TSR=0, DIV_CNT=0, synchronisers 0.
- IRQ=0, TOUT=0, IBUS_BUSY=0.
- Reset mid-count discards all state; there is no pending-event carry-over.

Decomposition:
- Package sh_tmu_pkg:
  - TCR/TSR bit-index constants.
  - Register offset constants (TCR, TCNT, TCOR, TSR).
  - CKS enum (CKS_1..CKS_4096, CKS_EXT).
  - Function tick_sel(cks, div_cnt).
- Sub-module sh_tmu_channel: one counter, compare, flags, IRQ and TOUT logic; instantiated NCH times via generate.
- Top level holds the prescaler, TCLK synchroniser, bus decode, readback mux and cascade wiring.

Test Plan:
- Reset then read every register of ch0 -> TCR=0, TCNT=0, TCOR=0x0000FFFF (CNT_W=16), TSR=0; IRQ=0, TOUT=0.
- ch0 TCOR=9, TCR=EN|CCLR|CMIE|TOE, CKS=0 -> TCNT counts 0..9, wraps to 0; CMF set and IRQ[0] high one cycle after match; TOUT[0] toggles every 10 ticks. Write TSR=1 -> IRQ[0] drops.
- ch1 CKS=2 (/16), OS=1, TCOR=3 -> match after 4 ticks = 64 CE_R cycles; EN self-clears; TCNT stays 0 when CCLR=1.
- ch0 TCNT=0xFFFE, ch1 CASC=1, both EN, TCOR=0xFFFF on both with CCLR=0 -> after ch0 wraps, ch1 TCNT=1; OVF set on ch0.
- CKS=7, 5 TCLK pulses each 4 CE_R wide -> TCNT=5, first increment 3 CE_R after the first rising edge.
- CPU writes TCNT=0x1234 on the same cycle as a tick -> TCNT reads 0x1234. Write-1-clear CMF coincident with a new match -> CMF stays 1.
